// File: rtl/sequential_subtractor_32bit_if.sv
// Operand/result bundle for the sequential subtractor.
// The master drives the request and operands. The slave returns status and the result.
interface sequential_subtractor_32bit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] DIFF;
    logic             Bout;
    logic             V;
    logic             Z;

    modport master (
        output start, A, B, Bin,
        input  busy, done, DIFF, Bout, V, Z
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, DIFF, Bout, V, Z
    );
endinterface

// File: rtl/sequential_subtractor_32bit.sv
// Multi-cycle subtractor: DIFF = A - B - Bin, computed one SLICE-bit slice per cycle, LSB first.
// Each slice computes A + ~B + carry. The carry chain starts at ~Bin.
//
// state | meaning
// IDLE  | waiting for start; last result held on outputs
// RUN   | processing slice idx_q; busy = 1
// DONE  | one-cycle done pulse; new start accepted here as in IDLE
module sequential_subtractor_32bit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    sequential_subtractor_32bit_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               v_q, v_d;
    logic               z_q, z_d;

    logic [SLICE-1:0]   a_sl, nb_sl, sum_sl;
    logic [SLICE:0]     sum_ext;
    logic               cout, c_msb_in, last;
    logic [WIDTH-1:0]   acc_full;

    // Slice adder for the current index. acc_full is the accumulator with this slice written in.
    always_comb begin
        a_sl     = a_q[int'(idx_q)*SLICE +: SLICE];
        nb_sl    = ~b_q[int'(idx_q)*SLICE +: SLICE];
        sum_ext  = {1'b0, a_sl} + {1'b0, nb_sl} + {{SLICE{1'b0}}, carry_q};
        sum_sl   = sum_ext[SLICE-1:0];
        cout     = sum_ext[SLICE];
        // Recover the carry into the slice MSB from that bit's sum.
        c_msb_in = a_sl[SLICE-1] ^ nb_sl[SLICE-1] ^ sum_sl[SLICE-1];
        acc_full = acc_q;
        acc_full[int'(idx_q)*SLICE +: SLICE] = sum_sl;
        last     = (idx_q == IDXW'(NSLICE - 1));
    end

    // Next-state and datapath update. Results are loaded only on the final slice.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        v_d     = v_q;
        z_d     = z_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = ~bus.Bin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                acc_d   = acc_full;
                carry_d = cout;
                idx_d   = idx_q + IDXW'(1);
                if (last) begin
                    state_d = DONE;
                    idx_d   = '0;
                    diff_d  = acc_full;
                    bout_d  = ~cout;
                    v_d     = c_msb_in ^ cout;
                    z_d     = (acc_full == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset is asynchronous and clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.DIFF = diff_q;
    assign bus.Bout = bout_q;
    assign bus.V    = v_q;
    assign bus.Z    = z_q;
endmodule

// File: tb/tb_sequential_subtractor_32bit.sv
// Directed bench for sequential_subtractor_32bit. Expected values are hand-computed constants.
module tb_sequential_subtractor_32bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] prev_diff = 32'h0;

    sequential_subtractor_32bit_if #(.WIDTH(32)) bus ();

    sequential_subtractor_32bit #(.WIDTH(32), .SLICE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Drive the operands on a negedge. The next posedge is the capture edge.
    // Check 4 busy cycles with the result held, then the done cycle and the result.
    // The call returns at the negedge inside the DONE cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic bin, input logic [31:0] ed, input logic eb,
                          input logic ev, input logic ez);
        bus.start = 1'b1; bus.A = a; bus.B = b; bus.Bin = bin;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
            check({tag, "_nodone"}, {31'b0, bus.done}, 32'd0);
            check({tag, "_hold"}, bus.DIFF, prev_diff);
        end
        @(negedge clk);
        check({tag, "_done"}, {31'b0, bus.done}, 32'd1);
        check({tag, "_idle"}, {31'b0, bus.busy}, 32'd0);
        check({tag, "_diff"}, bus.DIFF, ed);
        check({tag, "_bout"}, {31'b0, bus.Bout}, {31'b0, eb});
        check({tag, "_v"}, {31'b0, bus.V}, {31'b0, ev});
        check({tag, "_z"}, {31'b0, bus.Z}, {31'b0, ez});
        prev_diff = ed;
    endtask

    initial begin
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_diff", bus.DIFF, 32'h0);
        check("rst_flags", {29'b0, bus.Bout, bus.V, bus.Z}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        run_op("v036", 32'h5, 32'h3, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("v036_pulse", {31'b0, bus.done}, 32'd0);
        run_op("v037", 32'h0, 32'h1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        run_op("v038", 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        run_op("v039", 32'h100, 32'hFF, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Start 10-4. Pulse start with 1-2 in the first RUN cycle. That start must be ignored.
        // A and B then stay at 1 and 2 while 10-4 completes.
        bus.start = 1'b1; bus.A = 32'd10; bus.B = 32'd4; bus.Bin = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.A = 32'd1; bus.B = 32'd2;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("v040_busy", {31'b0, bus.busy}, 32'd1);
            check("v040_nodone", {31'b0, bus.done}, 32'd0);
        end
        @(negedge clk);
        check("v040_done", {31'b0, bus.done}, 32'd1);
        check("v040_diff", bus.DIFF, 32'd6);
        check("v040_bout", {31'b0, bus.Bout}, 32'd0);
        prev_diff = 32'd6;

        // Start 3-3 back to back in the DONE cycle.
        run_op("v041", 32'd3, 32'd3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("v041_pulse", {31'b0, bus.done}, 32'd0);

        // This leaves nonzero DIFF, Bout and V, so the reset check below is meaningful.
        run_op("vpre", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);

        // Abort in the 2nd RUN cycle with an asynchronous reset.
        bus.start = 1'b1; bus.A = 32'h12345678; bus.B = 32'h1; bus.Bin = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("v042_busy", {31'b0, bus.busy}, 32'd0);
        check("v042_done", {31'b0, bus.done}, 32'd0);
        check("v042_diff", bus.DIFF, 32'h0);
        check("v042_bout", {31'b0, bus.Bout}, 32'd0);
        check("v042_v", {31'b0, bus.V}, 32'd0);
        check("v042_z", {31'b0, bus.Z}, 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("v042_nodone", {30'b0, bus.busy, bus.done}, 32'd0);
        end
        prev_diff = 32'h0;
        run_op("v042b", 32'd7, 32'd2, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("v042b_pulse", {31'b0, bus.done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
